// File: rtl/spi_cmd_queue_if.sv
// CPU-side command push/flush/status and SPI-driver handshake for spi_cmd_queue.
// The slave modport is the queue; the master modport is the CPU/driver environment.
interface spi_cmd_queue_if;
    logic       wr;
    logic [9:0] wdata;
    logic       clr;
    logic       spi_cs_n;
    logic       spi_start;
    logic [9:0] spi_din;
    logic [7:0] status;

    modport slave  (input  wr, wdata, clr, spi_cs_n,
                    output spi_start, spi_din, status);
    modport master (output wr, wdata, clr, spi_cs_n,
                    input  spi_start, spi_din, status);
endinterface

// File: rtl/spi_cmd_queue.sv
// Command FIFO feeding an SPI driver: issues one word at a time, waits for the
// driver's chip-select cycle (or times out), then enforces an idle gap.
module spi_cmd_queue #(
    parameter int DEPTH   = 16,
    parameter int GAP     = 4,
    parameter int ACK_TMO = 4
) (
    input  logic            clk,
    input  logic            reset_,
    spi_cmd_queue_if.slave  bus
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMAX = (GAP > ACK_TMO) ? GAP : ACK_TMO;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ACKW, BUSY, HOLD} state_e;

    state_e          state_q, state_d;
    logic [9:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [4:0]      level_q, level_d;
    logic            ovf_q, ovf_d, err_q, err_d, busy_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [9:0]      din_q, din_d;
    logic            full, push, pop, err_set;

    assign full = (level_q == 5'(DEPTH));
    assign pop  = (state_q == ISSUE);
    assign push = bus.wr && !full && !bus.clr;

    // Sequencer; the shared counter restarts at zero on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        din_d   = din_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in the same cycle must not launch a word being discarded.
                if (level_q != 5'd0 && !bus.clr) begin
                    state_d = ISSUE;
                    din_d   = mem_q[rptr_q];
                end
            end
            ISSUE: state_d = din_q[9] ? HOLD : ACKW;
            ACKW: begin
                if (!bus.spi_cs_n) begin
                    state_d = BUSY;
                end else if (cnt_q == CW'(ACK_TMO - 1)) begin
                    err_set = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BUSY: if (bus.spi_cs_n) state_d = HOLD;
            HOLD: begin
                if (cnt_q == CW'(GAP - 1)) state_d = IDLE;
                else                       cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; flush wins over push, pop and a same-cycle timeout.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        err_d   = err_q | err_set;
        if (bus.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (bus.wr && full) ovf_d  = 1'b1;
            if (push)           wptr_d = wptr_q + AW'(1);
            if (pop)            rptr_d = rptr_q + AW'(1);
            level_d = level_q + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
            cnt_q   <= cnt_d;
            din_q   <= din_d;
        end
    end

    assign bus.spi_start = (state_q == ISSUE);
    assign bus.spi_din   = din_q;
    assign bus.status    = {err_q, ovf_q, busy_q, level_q};
endmodule

// File: tb/tb_spi_cmd_queue.sv
// Randomized bench for spi_cmd_queue against a timestamp-based queue model:
// each issue is scheduled arithmetically from the driver response it is given.
module tb_spi_cmd_queue;
    localparam int DEPTH = 16, GAP = 4, ACK_TMO = 4;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    spi_cmd_queue_if bus();

    spi_cmd_queue #(.DEPTH(DEPTH), .GAP(GAP), .ACK_TMO(ACK_TMO)) dut (
        .clk(clk), .reset_(reset_), .bus(bus)
    );

    always #8 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0, n_start = 0;
    logic [9:0] q[$];
    logic [9:0] issued[$];
    bit         m_ovf, m_err;
    logic [9:0] m_din;
    int idle_at, issue_cyc, err_cyc, cs_lo, cs_hi;
    int drv_mode = 0, fix_d = 1, fix_l = 2;   // 0 random, 1 never answers, 2 fixed

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, want);
        end
    endtask

    task automatic compare();
        chk("status", {8'h0, bus.status},
            {8'h0, m_err, m_ovf, (cyc < idle_at), 5'(q.size())});
        chk("start", 16'(bus.spi_start), 16'(cyc == issue_cyc));
        chk("din", 16'(bus.spi_din), 16'(m_din));
        if (bus.spi_start === 1'b1) begin
            n_start++;
            issued.push_back(bus.spi_din);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_err = 0; m_din = '0;
        idle_at = cyc; issue_cyc = -1; err_cyc = -1; cs_lo = 0; cs_hi = 0;
    endtask

    // Plan the driver's answer to an issue at cycle t and when the queue is free again.
    task automatic schedule(input int t, input logic [9:0] w);
        int d, l;
        bit tmo;
        cs_lo = 0; cs_hi = 0;
        if (w[9]) begin
            idle_at = t + 1 + GAP;
            return;
        end
        tmo = (drv_mode == 1) || (drv_mode == 0 && $urandom_range(0, 3) == 0);
        d = (drv_mode == 2) ? fix_d : $urandom_range(1, ACK_TMO);
        l = (drv_mode == 2) ? fix_l : $urandom_range(1, 6);
        if (tmo) begin
            err_cyc = t + ACK_TMO;
            idle_at = t + ACK_TMO + 1 + GAP;
        end else begin
            cs_lo   = t + d;
            cs_hi   = t + d + l;
            idle_at = t + d + l + 1 + GAP;
        end
    endtask

    task automatic model_step(input logic w, input logic [9:0] d, input logic c);
        bit idle = (cyc >= idle_at);
        int sz = q.size();
        logic [9:0] head = (sz > 0) ? q[0] : 10'h0;
        if (cyc == err_cyc) m_err = 1;
        if (c) begin
            q.delete(); m_ovf = 0; m_err = 0;
        end else begin
            if (cyc == issue_cyc) void'(q.pop_front());
            if (w) begin
                if (sz == DEPTH) m_ovf = 1;
                else             q.push_back(d);
            end
        end
        if (idle && sz > 0 && !c) begin
            issue_cyc = cyc + 1;
            m_din = head;
            schedule(cyc + 1, head);
        end
    endtask

    task automatic tick(input logic w, input logic [9:0] d, input logic c);
        bus.wr = w; bus.wdata = d; bus.clr = c;
        bus.spi_cs_n = !(cyc >= cs_lo && cyc < cs_hi);
        model_step(w, d, c);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 10'h0, 1'b0);
    endtask

    task automatic do_reset();
        bus.wr = 0; bus.wdata = '0; bus.clr = 0; bus.spi_cs_n = 1;
        reset_ = 1'b0;
        model_reset();
        #1 compare();
        repeat (2) begin
            @(posedge clk); cyc++;
            @(negedge clk); compare();
        end
        reset_ = 1'b1;
    endtask

    initial begin
        #(16 * 100000);
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [9:0] w;
        bus.wr = 0; bus.wdata = '0; bus.clr = 0; bus.spi_cs_n = 1;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_status", {8'h0, bus.status}, 16'h0000);

        // Single command, driver answers one cycle after start for 400 cycles.
        drv_mode = 2; fix_d = 1; fix_l = 400;
        s0 = n_start;
        tick(1, 10'h0AE, 0);
        idle(420);
        chk("r030_starts", 16'(n_start - s0), 16'd1);
        chk("r030_din", 16'(issued[$]), 16'h0AE);
        chk("r030_status", {8'h0, bus.status}, 16'h0000);

        // Power-on word skips the chip-select wait.
        tick(1, 10'h200, 0);
        idle(GAP + 4);
        chk("r031_din", 16'(issued[$]), 16'h200);
        chk("r031_status", {8'h0, bus.status}, 16'h0000);

        // Overflow while the driver holds a long transfer.
        fix_l = 150;
        tick(1, 10'h0FF, 0);
        idle(3);
        s0 = issued.size();
        for (int k = 1; k <= 17; k++) tick(1, 10'(k), 0);
        chk("r032_full", {8'h0, bus.status}, 16'h0070);
        fix_l = 2;
        idle(330);
        chk("r032_count", 16'(issued.size() - s0), 16'd16);
        for (int k = 1; k <= 16; k++) chk("r032_order", 16'(issued[s0 + k - 1]), 16'(k));

        // Driver never answers: timeout sets err, queue keeps draining, flush clears.
        tick(0, 10'h0, 1);
        drv_mode = 1;
        tick(1, 10'h011, 0);
        idle(ACK_TMO + 3);
        chk("r033_err", 16'(bus.status[7]), 16'd1);
        tick(1, 10'h022, 0);
        tick(1, 10'h033, 0);
        idle(40);
        chk("r033_drain", 16'(issued[$]), 16'h033);
        tick(0, 10'h0, 1);
        chk("r033_clr", {8'h0, bus.status}, 16'h0000);

        // Push lands in the very cycle the only entry is popped.
        drv_mode = 2; fix_d = 1; fix_l = 3;
        tick(1, 10'h155, 0);
        tick(0, 10'h0, 0);
        chk("r034_start", 16'(bus.spi_start), 16'd1);
        tick(1, 10'h0AA, 0);
        chk("r034_level", 16'(bus.status[4:0]), 16'd1);
        idle(20);
        chk("r034_next", 16'(issued[$]), 16'h0AA);

        // Random traffic with random driver behaviour and occasional flushes.
        drv_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            w = 10'($urandom);
            if ($urandom_range(0, 7) != 0) w[9] = 1'b0;
            tick($urandom_range(0, 9) < 3, w, $urandom_range(0, 99) == 0);
        end
        idle(300);
        tick(0, 10'h0, 1);

        // Reset in the middle of a transfer with words queued.
        drv_mode = 2; fix_d = 1; fix_l = 300;
        tick(1, 10'h0C3, 0);
        idle(3);
        for (int k = 0; k < 5; k++) tick(1, 10'h100 + 10'(k), 0);
        chk("r035_pre", {8'h0, bus.status}, 16'h0025);
        do_reset();
        chk("r035_rst", {8'h0, bus.status}, 16'h0000);
        s0 = n_start;
        idle(30);
        chk("r035_quiet", 16'(n_start - s0), 16'd0);
        drv_mode = 0;
        tick(1, 10'h0E1, 0);
        idle(30);
        chk("r035_resume", 16'(issued[$]), 16'h0E1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
